apb_req_arbiter: RTL
====================

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of APB address.
REQ-002 Parameter DATA_WIDTH, default 32, width of APB write/read data.
REQ-003 Parameter NUM_REQ, default 4, number of requesters; legal range 2..8.
REQ-004 Parameter TIMEOUT_CYCLES, default 64, BUSY-state cycle limit; used only under REQ-030.
REQ-005 Port list SHALL be:
  PCLK  in  1  sole clock; all logic on rising edge.
  PRESETn  in  1  asynchronous, active-low reset.
  req  in  NUM_REQ  per-requester transfer request, level.
  req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
  req_wr  in  NUM_REQ  per-requester direction (1 = write).
  req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
  gnt  out  NUM_REQ  one-hot grant, held from grant until done.
  done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
  req_rdata  out  DATA_WIDTH  read data of the last completed transfer.
  req_slverr  out  1  error status of the last completed transfer.
  busy  out  1  high in ISSUE and BUSY.
  start_transfer  out  1  one-cycle start pulse to the APB master.
  addr  out  ADDR_WIDTH  address to the APB master.
  wr  out  1  direction to the APB master.
  wdata  out  DATA_WIDTH  write data to the APB master.
  rdata  in  DATA_WIDTH  read data returned by the APB master.
  slverr  in  1  error returned by the APB master.
  PSEL, PENABLE, PREADY  in  1 each  APB bus taps for completion detection.

Function
REQ-006 FSM states IDLE, ISSUE, BUSY; all outputs SHALL be registered.
REQ-007 IDLE: if any req bit is high, the arbiter SHALL select the winner round-robin, starting the search at (last+1) mod NUM_REQ, and go to ISSUE; otherwise it stays in IDLE.
REQ-008 On the IDLE->ISSUE edge, gnt[winner] SHALL be set, and the winner's addr, wr and wdata SHALL be latched onto addr, wr and wdata.
REQ-009 ISSUE SHALL last exactly one cycle with start_transfer=1, then go to BUSY; start_transfer SHALL be 0 in every other state.
REQ-010 Latency: req seen high at edge N SHALL produce gnt and start_transfer high from edge N+1.
REQ-011 addr, wr and wdata SHALL stay stable from ISSUE until done; requester inputs are ignored after the latch.
REQ-012 BUSY: completion is PSEL & PENABLE & PREADY at a rising edge; on that edge the arbiter SHALL capture rdata and slverr into req_rdata and req_slverr, pulse done[granted] for one cycle, clear gnt, set last=granted, and return to IDLE.
REQ-013 Deasserting req after grant SHALL NOT abort the transfer; the transfer runs to completion.
REQ-014 A requester still asserting req in the cycle after done SHALL be treated as a new request.
REQ-015 Back-to-back transfers: the minimum gap is one IDLE cycle between done and the next start_transfer.
REQ-016 Simultaneous requests SHALL be served round-robin; no requester waits more than NUM_REQ-1 grants.
REQ-017 req_rdata and req_slverr SHALL hold their values until the next completion.

Reset
REQ-018 PRESETn low SHALL immediately force state=IDLE, gnt=0, done=0, start_transfer=0, busy=0, addr=0, wr=0, wdata=0, req_rdata=0, req_slverr=0, and last=NUM_REQ-1, so requester 0 wins first.
REQ-019 Reset asserted mid-transfer SHALL abandon the transfer with no done pulse.

Configuration
REQ-030 With macro APB_ARB_TIMEOUT_EN defined, a BUSY counter SHALL run; if no completion occurs after TIMEOUT_CYCLES cycles in BUSY, the arbiter SHALL pulse done with req_slverr=1 and req_rdata=0, then return to IDLE.
REQ-031 Without APB_ARB_TIMEOUT_EN, the counter SHALL be absent and BUSY SHALL wait indefinitely.

Verification
REQ-040 Single request: req=4'b0010, addr1=0x100, wr=1, PREADY=1 on the second cycle of BUSY -> gnt=0010 and start_transfer pulse at the next edge, addr=0x100, done[1] pulses once.
REQ-041 Round-robin: req=4'b1111 held -> grants in order 0,1,2,3,0, each separated by done.
REQ-042 Read with wait states: req0 read, PREADY low for 3 cycles, rdata=0xDEADBEEF -> done[0] after completion, req_rdata=0xDEADBEEF, req_slverr=0.
REQ-043 Error: slverr=1 at completion -> req_slverr=1, done pulses, next transfer proceeds normally.
REQ-044 Reset mid-BUSY: PRESETn low for 1 cycle -> all outputs 0, no done pulse, next grant goes to requester 0.
REQ-045 With APB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, PREADY stuck at 0 -> done after 8 BUSY cycles with req_slverr=1.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// -----------------------------------------------------------------------------
// apb_req_arbiter
//
// Round-robin arbiter that funnels NUM_REQ requesters onto a single APB master.
// The winner's address/direction/write data are latched when it is granted and
// held until the transfer completes (PSEL & PENABLE & PREADY seen in BUSY).
// The completed transfer's read data and error are captured and held until the
// next completion.
//
// Optional feature: define APB_ARB_TIMEOUT_EN to add a BUSY watchdog. After
// TIMEOUT_CYCLES cycles in BUSY without completion, the transfer is closed with
// done pulsed, req_slverr=1 and req_rdata=0.
//
// Ports
//   PCLK, PRESETn        clock, asynchronous active-low reset
//   req/req_addr/req_wr/req_wdata   per-requester request and transfer fields
//   gnt, done            one-hot grant (held) and one-cycle completion pulse
//   req_rdata, req_slverr  result of the last completed transfer
//   busy                 high while a transfer is being issued or in flight
//   start_transfer, addr, wr, wdata   command to the APB master
//   rdata, slverr        response from the APB master
//   PSEL, PENABLE, PREADY   APB bus taps used for completion detection
// -----------------------------------------------------------------------------
module apb_req_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                          PCLK,
   input  logic                          PRESETn,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ-1:0]            req_wr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            done,
   output logic [DATA_WIDTH-1:0]         req_rdata,
   output logic                          req_slverr,
   output logic                          busy,
   output logic                          start_transfer,
   output logic [ADDR_WIDTH-1:0]         addr,
   output logic                          wr,
   output logic [DATA_WIDTH-1:0]         wdata,
   input  logic [DATA_WIDTH-1:0]         rdata,
   input  logic                          slverr,
   input  logic                          PSEL,
   input  logic                          PENABLE,
   input  logic                          PREADY
);

   localparam int IW = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("apb_req_arbiter: illegal parameter value");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

   state_t          state_reg;
   logic [IW-1:0]   last_reg;   // index of the most recently completed requester
   logic [IW-1:0]   cur_reg;    // index of the requester currently granted

   // Unpacked views of the packed requester buses
   logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
   logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
   end

   // Round-robin search starting just after the last served requester
   logic [IW-1:0] win_next;
   logic          win_valid;
   logic [IW-1:0] idx_w;

   always_comb begin
      win_next  = '0;
      win_valid = 1'b0;
      idx_w     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx_w = IW'((int'(last_reg) + k) % NUM_REQ);
         if (!win_valid && req[idx_w]) begin
            win_next  = idx_w;
            win_valid = 1'b1;
         end
      end
   end

   logic apb_done;
   assign apb_done = PSEL & PENABLE & PREADY;

`ifdef APB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] tmo_cnt_reg;
`endif

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_reg      <= IDLE;
         last_reg       <= IW'(NUM_REQ - 1);
         cur_reg        <= '0;
         gnt            <= '0;
         done           <= '0;
         req_rdata      <= '0;
         req_slverr     <= 1'b0;
         busy           <= 1'b0;
         start_transfer <= 1'b0;
         addr           <= '0;
         wr             <= 1'b0;
         wdata          <= '0;
`ifdef APB_ARB_TIMEOUT_EN
         tmo_cnt_reg    <= '0;
`endif
      end else begin
         // Pulses default low every cycle
         done           <= '0;
         start_transfer <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (win_valid) begin
                  state_reg      <= ISSUE;
                  cur_reg        <= win_next;
                  gnt            <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_next;
                  addr           <= addr_arr[win_next];
                  wr             <= req_wr[win_next];
                  wdata          <= wdata_arr[win_next];
                  start_transfer <= 1'b1;
                  busy           <= 1'b1;
               end
            end
            ISSUE: begin
               state_reg <= BUSY;
`ifdef APB_ARB_TIMEOUT_EN
               tmo_cnt_reg <= '0;
`endif
            end
            BUSY: begin
               if (apb_done) begin
                  state_reg     <= IDLE;
                  req_rdata     <= rdata;
                  req_slverr    <= slverr;
                  done[cur_reg] <= 1'b1;
                  gnt           <= '0;
                  busy          <= 1'b0;
                  last_reg      <= cur_reg;
               end
`ifdef APB_ARB_TIMEOUT_EN
               else if (tmo_cnt_reg == CW'(TIMEOUT_CYCLES - 1)) begin
                  // Watchdog expiry closes the transfer as an error
                  state_reg     <= IDLE;
                  req_rdata     <= '0;
                  req_slverr    <= 1'b1;
                  done[cur_reg] <= 1'b1;
                  gnt           <= '0;
                  busy          <= 1'b0;
                  last_reg      <= cur_reg;
               end else begin
                  tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
               end
`endif
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
